tone_sequencer: RTL and testbench
=================================

// Module: tone_sequencer
// PURPOSE
//  Melody sequencer feeding the divisor input m of the clock divider; the divider's SLOW_CLOCK drives the buzzer.
//  Steps through a fixed note table. Holds each note's divisor for a programmed number of duration units.
//  Mutes between notes and at rests via TONE_EN, which gates SLOW_CLOCK at the audio pin.
//  Divider relation: f_out = CLK_HZ / (2*(m+1)), so m = CLK_HZ/(2*f) - 1 (A4 440 Hz -> 113635).
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency; documentation and divisor constants only
//  TICK_DIV    6_250_000    CLOCK cycles per duration unit (16 units/s); must be >= 1
//  GAP_UNITS   1            silent units inserted after every note; 0 = no gap
//  NOTE_COUNT  16           note table depth
//  ADDR_W      4            table index width, clog2(NOTE_COUNT)
// PORTS
//  CLOCK     in   1       system clock; everything is on posedge
//  RESET     in   1       synchronous, active-high reset
//  START     in   1       1-cycle request to begin playback at entry 0; ignored while BUSY
//  STOP      in   1       abort playback; priority over START
//  LOOP      in   1       sampled at end of melody: 1 = restart at entry 0, 0 = finish
//  m         out  32      divisor to the clock divider; 0 whenever TONE_EN=0
//  TONE_EN   out  1       1 while a non-rest note sounds
//  BUSY      out  1       1 in PLAY and GAP states
//  NOTE_IDX  out  ADDR_W  index of the current table entry
//  DONE      out  1       1-cycle pulse when a non-looping melody ends
// BEHAVIOUR
//  - Table entry = {div[31:0], dur[7:0]}.
//  - div=0 is a rest: TONE_EN=0, m=0, duration still counted.
//  - dur=0 is the end-of-melody terminator; the terminator entry is never played.
//  - Reset: state IDLE; m=0, TONE_EN=0, BUSY=0, NOTE_IDX=0, DONE=0; prescaler and unit counter cleared.
//  - States: IDLE, PLAY, GAP, FINISH.
//  - IDLE: on START (and STOP=0), the next cycle is PLAY with NOTE_IDX=0, m=div[0], TONE_EN=(div[0]!=0), BUSY=1.
//  - Outputs are registered, so there is 1 cycle of latency from START to the first m.
//  - PLAY: the entry is held exactly dur*TICK_DIV cycles. The prescaler restarts at 0 on every state entry.
//  - PLAY exit: GAP if GAP_UNITS>0, otherwise straight to the next entry.
//  - GAP: m=0, TONE_EN=0, NOTE_IDX unchanged, BUSY=1; lasts exactly GAP_UNITS*TICK_DIV cycles.
//  - Next entry: idx+1, wrapping NOTE_COUNT-1 -> 0.
//  - End of melody: the next entry has dur=0, or the index wraps. Then:
//      LOOP=1: PLAY entry 0 with no extra cycle.
//      LOOP=0: FINISH for 1 cycle with DONE=1, BUSY=0, m=0, TONE_EN=0; then IDLE.
//  - Entry 0 with dur=0 (empty melody): START goes straight to FINISH.
//  - STOP in any state: next cycle is IDLE with reset values, no DONE.
//  - START and STOP in the same cycle: STOP wins.
//  - RESET mid-note: same as STOP, and all counters clear.
//  - START while BUSY or in FINISH: ignored; no restart.
//  - LOOP is sampled only on the end-of-melody cycle.
//  - Prescaler width: 32 bits, counts 0..TICK_DIV-1. Unit counter: 8 bits. No overflow is possible.
// STRUCTURE
//  - Shared header tone_defs.vh:
//      note divisor constants (NOTE_C4..NOTE_B5, NOTE_REST=0) computed for CLK_HZ=100 MHz;
//      DUR_* unit constants; state encodings.
//  - Sub-module tone_rom: combinational case table, input ADDR_W index, output {div, dur}.
//      Swapping melodies touches only tone_rom.
//  - tone_sequencer holds the FSM, prescaler, unit counter and output registers.
// TESTING (TICK_DIV=4, GAP_UNITS=1; test ROM {1000,2},{0,1},{2000,1},{x,0})
//  1 RESET 3 cycles -> all outputs 0.
//    START pulse -> next cycle m=1000, TONE_EN=1, BUSY=1, NOTE_IDX=0.
//  2 Timing:
//      m=1000 held 8 cycles, then gap (m=0) 4 cycles;
//      rest at idx1: 4 cycles TONE_EN=0, then 4 gap;
//      m=2000 4 cycles, then 4 gap;
//      then FINISH: DONE=1 for exactly 1 cycle; then IDLE.
//  3 LOOP=1 held -> after the idx2 gap, NOTE_IDX=0 and m=1000 on the next cycle; DONE never asserts.
//  4 STOP during idx0 note (cycle 3) -> next cycle m=0, BUSY=0, NOTE_IDX=0, no DONE.
//    START+STOP in the same cycle from IDLE -> stays IDLE.
//  5 Extra START pulses while BUSY -> sequence timing identical to scenario 2.
//    RESET asserted mid-gap -> IDLE next cycle, all outputs 0.
//  6 Edge cases:
//      full ROM of 16 entries with dur=1 and no terminator, LOOP=0 -> idx wraps 15->0 and DONE pulses;
//      ROM entry 0 dur=0 -> START gives DONE on the 2nd cycle and BUSY stays 0.

Source files
------------

// File: rtl/tone_sequencer_pkg.sv
// ============================================================================
//  Module   : tone_sequencer_pkg
//  Purpose  : Shared types, note divisors, durations and melody selectors
//             for the tone sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tone_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [31:0] div;
        logic [7:0]  dur;
    } tone_entry_t;

    // Note lengths in duration units (16 units per second at the default tick)
    localparam logic [7:0] DUR_END       = 8'd0;
    localparam logic [7:0] DUR_SIXTEENTH = 8'd1;
    localparam logic [7:0] DUR_EIGHTH    = 8'd2;
    localparam logic [7:0] DUR_QUARTER   = 8'd4;
    localparam logic [7:0] DUR_HALF      = 8'd8;
    localparam logic [7:0] DUR_WHOLE     = 8'd16;

    // Pitches in centi-hertz
    localparam longint unsigned CHZ_C4 = 26163;
    localparam longint unsigned CHZ_D4 = 29366;
    localparam longint unsigned CHZ_E4 = 32963;
    localparam longint unsigned CHZ_F4 = 34923;
    localparam longint unsigned CHZ_G4 = 39200;
    localparam longint unsigned CHZ_A4 = 44000;
    localparam longint unsigned CHZ_B4 = 49388;
    localparam longint unsigned CHZ_C5 = 52325;
    localparam longint unsigned CHZ_D5 = 58733;
    localparam longint unsigned CHZ_E5 = 65926;
    localparam longint unsigned CHZ_F5 = 69846;
    localparam longint unsigned CHZ_G5 = 78399;
    localparam longint unsigned CHZ_A5 = 88000;
    localparam longint unsigned CHZ_B5 = 98777;

    // m = CLK_HZ / (2*f) - 1, with f supplied in centi-hertz
    function automatic logic [31:0] note_div(input longint unsigned clk_hz,
                                             input longint unsigned centi_hz);
        longint unsigned q;
        q = (clk_hz * 64'd100) / (64'd2 * centi_hz);
        return 32'(q - 64'd1);
    endfunction

    localparam logic [31:0] NOTE_REST = 32'd0;
    localparam logic [31:0] NOTE_C4   = note_div(100_000_000, CHZ_C4);
    localparam logic [31:0] NOTE_D4   = note_div(100_000_000, CHZ_D4);
    localparam logic [31:0] NOTE_E4   = note_div(100_000_000, CHZ_E4);
    localparam logic [31:0] NOTE_F4   = note_div(100_000_000, CHZ_F4);
    localparam logic [31:0] NOTE_G4   = note_div(100_000_000, CHZ_G4);
    localparam logic [31:0] NOTE_A4   = note_div(100_000_000, CHZ_A4);
    localparam logic [31:0] NOTE_B4   = note_div(100_000_000, CHZ_B4);
    localparam logic [31:0] NOTE_C5   = note_div(100_000_000, CHZ_C5);
    localparam logic [31:0] NOTE_D5   = note_div(100_000_000, CHZ_D5);
    localparam logic [31:0] NOTE_E5   = note_div(100_000_000, CHZ_E5);
    localparam logic [31:0] NOTE_F5   = note_div(100_000_000, CHZ_F5);
    localparam logic [31:0] NOTE_G5   = note_div(100_000_000, CHZ_G5);
    localparam logic [31:0] NOTE_A5   = note_div(100_000_000, CHZ_A5);
    localparam logic [31:0] NOTE_B5   = note_div(100_000_000, CHZ_B5);

    // Melody selectors for tone_rom
    localparam int MEL_DEFAULT = 0;
    localparam int MEL_TEST    = 1;
    localparam int MEL_WRAP    = 2;
    localparam int MEL_EMPTY   = 3;

endpackage

`default_nettype wire

// File: rtl/tone_rom.sv
// ============================================================================
//  Module   : tone_rom
//  Purpose  : Combinational melody table returning {div, dur} per index.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_rom
    import tone_sequencer_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int CLK_HZ = 100_000_000,
    parameter int MELODY = MEL_DEFAULT
) (
    input  logic [ADDR_W-1:0] i_addr,
    output tone_entry_t       o_entry
);

    generate
        if (MELODY == MEL_TEST) begin : g_test
            always_comb begin
                o_entry = '{div: 32'd0, dur: DUR_END};
                case (int'(i_addr))
                    0: o_entry = '{div: 32'd1000, dur: 8'd2};
                    1: o_entry = '{div: NOTE_REST, dur: 8'd1};
                    2: o_entry = '{div: 32'd2000, dur: 8'd1};
                    3: o_entry = '{div: 32'd3000, dur: DUR_END};
                    default: o_entry = '{div: 32'd0, dur: DUR_END};
                endcase
            end
        end else if (MELODY == MEL_WRAP) begin : g_wrap
            // Every slot plays for one unit; there is no terminator, so the index wraps
            always_comb begin
                o_entry = '{div: (32'(i_addr) + 32'd1) * 32'd100, dur: DUR_SIXTEENTH};
            end
        end else if (MELODY == MEL_EMPTY) begin : g_empty
            always_comb begin
                o_entry = '{div: 32'(i_addr) + 32'd500, dur: DUR_END};
            end
        end else begin : g_default
            always_comb begin
                o_entry = '{div: NOTE_REST, dur: DUR_END};
                case (int'(i_addr))
                    0:  o_entry = '{div: note_div(64'(CLK_HZ), CHZ_C4), dur: DUR_QUARTER};
                    1:  o_entry = '{div: note_div(64'(CLK_HZ), CHZ_D4), dur: DUR_QUARTER};
                    2:  o_entry = '{div: note_div(64'(CLK_HZ), CHZ_E4), dur: DUR_QUARTER};
                    3:  o_entry = '{div: note_div(64'(CLK_HZ), CHZ_C4), dur: DUR_QUARTER};
                    4:  o_entry = '{div: NOTE_REST,                     dur: DUR_EIGHTH};
                    5:  o_entry = '{div: note_div(64'(CLK_HZ), CHZ_E4), dur: DUR_QUARTER};
                    6:  o_entry = '{div: note_div(64'(CLK_HZ), CHZ_F4), dur: DUR_QUARTER};
                    7:  o_entry = '{div: note_div(64'(CLK_HZ), CHZ_G4), dur: DUR_HALF};
                    8:  o_entry = '{div: NOTE_REST,                     dur: DUR_QUARTER};
                    9:  o_entry = '{div: note_div(64'(CLK_HZ), CHZ_G4), dur: DUR_EIGHTH};
                    10: o_entry = '{div: note_div(64'(CLK_HZ), CHZ_A4), dur: DUR_EIGHTH};
                    11: o_entry = '{div: note_div(64'(CLK_HZ), CHZ_G4), dur: DUR_EIGHTH};
                    12: o_entry = '{div: note_div(64'(CLK_HZ), CHZ_F4), dur: DUR_EIGHTH};
                    13: o_entry = '{div: note_div(64'(CLK_HZ), CHZ_E4), dur: DUR_QUARTER};
                    14: o_entry = '{div: note_div(64'(CLK_HZ), CHZ_C4), dur: DUR_HALF};
                    default: o_entry = '{div: NOTE_REST, dur: DUR_END};
                endcase
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/tone_sequencer.sv
// ============================================================================
//  Module   : tone_sequencer
//  Purpose  : Steps through the tone_rom melody, driving the clock-divider
//             divisor m with per-note durations, inter-note gaps and looping.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_sequencer
    import tone_sequencer_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_DIV   = 6_250_000,
    parameter int GAP_UNITS  = 1,
    parameter int NOTE_COUNT = 16,
    parameter int ADDR_W     = 4,
    parameter int MELODY     = MEL_DEFAULT
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              START,
    input  logic              STOP,
    input  logic              LOOP,
    output logic [31:0]       m,
    output logic              TONE_EN,
    output logic              BUSY,
    output logic [ADDR_W-1:0] NOTE_IDX,
    output logic              DONE
);

    localparam logic [31:0]       c_TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [7:0]        c_GAP_LAST  = 8'(GAP_UNITS - 1);
    localparam logic              c_HAS_GAP   = (GAP_UNITS > 0);
    localparam logic [ADDR_W-1:0] c_LAST_IDX  = ADDR_W'(NOTE_COUNT - 1);

    seq_state_t        r_state;
    logic [31:0]       r_pre;
    logic [7:0]        r_units;
    logic [7:0]        r_dur;
    logic [31:0]       r_m;
    logic              r_tone_en;
    logic              r_busy;
    logic [ADDR_W-1:0] r_idx;
    logic              r_done;

    logic [ADDR_W-1:0] w_next_idx;
    tone_entry_t       w_next;
    tone_entry_t       w_first;
    tone_entry_t       w_load;
    logic [ADDR_W-1:0] w_load_idx;
    logic              w_tick_end;
    logic              w_play_done;
    logic              w_gap_done;
    logic              w_advance;
    logic              w_end;

    assign w_next_idx = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;

    tone_rom #(
        .ADDR_W (ADDR_W),
        .CLK_HZ (CLK_HZ),
        .MELODY (MELODY)
    ) u_rom_next (
        .i_addr  (w_next_idx),
        .o_entry (w_next)
    );

    tone_rom #(
        .ADDR_W (ADDR_W),
        .CLK_HZ (CLK_HZ),
        .MELODY (MELODY)
    ) u_rom_first (
        .i_addr  ('0),
        .o_entry (w_first)
    );

    assign w_tick_end  = (r_pre == c_TICK_LAST);
    assign w_play_done = w_tick_end && (r_units == r_dur - 8'd1);
    assign w_gap_done  = w_tick_end && (r_units == c_GAP_LAST);
    assign w_advance   = ((r_state == ST_PLAY) && w_play_done && !c_HAS_GAP) ||
                         ((r_state == ST_GAP) && w_gap_done);

    // End of melody: a terminator is next, or the table index wraps
    assign w_end      = (r_idx == c_LAST_IDX) || (w_next.dur == DUR_END);
    assign w_load     = w_end ? w_first : w_next;
    assign w_load_idx = w_end ? '0 : w_next_idx;

    always_ff @(posedge CLOCK) begin
        if (RESET || STOP) begin
            r_state   <= ST_IDLE;
            r_pre     <= '0;
            r_units   <= '0;
            r_dur     <= '0;
            r_m       <= '0;
            r_tone_en <= 1'b0;
            r_busy    <= 1'b0;
            r_idx     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_pre   <= '0;
                        r_units <= '0;
                        r_idx   <= '0;
                        if (w_first.dur == DUR_END) begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_PLAY;
                            r_m       <= w_first.div;
                            r_tone_en <= (w_first.div != '0);
                            r_dur     <= w_first.dur;
                            r_busy    <= 1'b1;
                        end
                    end
                end

                ST_PLAY, ST_GAP: begin
                    if (w_tick_end) begin
                        r_pre   <= '0;
                        r_units <= r_units + 8'd1;
                    end else begin
                        r_pre <= r_pre + 32'd1;
                    end

                    if ((r_state == ST_PLAY) && w_play_done && c_HAS_GAP) begin
                        r_state   <= ST_GAP;
                        r_units   <= '0;
                        r_m       <= '0;
                        r_tone_en <= 1'b0;
                    end

                    if (w_advance) begin
                        r_units <= '0;
                        r_idx   <= w_load_idx;
                        if (w_end && !LOOP) begin
                            r_state   <= ST_FINISH;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_m       <= '0;
                            r_tone_en <= 1'b0;
                        end else begin
                            r_state   <= ST_PLAY;
                            r_m       <= w_load.div;
                            r_tone_en <= (w_load.div != '0);
                            r_dur     <= w_load.dur;
                        end
                    end
                end

                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m        = r_m;
    assign TONE_EN  = r_tone_en;
    assign BUSY     = r_busy;
    assign NOTE_IDX = r_idx;
    assign DONE     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tone_sequencer.sv
// ============================================================================
//  Module   : tb_tone_sequencer
//  Purpose  : Directed self-checking bench for tone_sequencer (test, wrap and
//             empty melodies at TICK_DIV=4, GAP_UNITS=1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tone_sequencer;
    import tone_sequencer_pkg::*;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;
    logic STOP  = 1'b0;
    logic LOOP  = 1'b0;
    logic a_start = 1'b0;
    logic b_start = 1'b0;
    logic c_start = 1'b0;

    logic [31:0] a_m, b_m, c_m;
    logic        a_ten, b_ten, c_ten;
    logic        a_busy, b_busy, c_busy;
    logic [3:0]  a_idx, b_idx, c_idx;
    logic        a_done, b_done, c_done;

    logic [38:0] obs_a, obs_b, obs_c;
    assign obs_a = {a_m, a_ten, a_busy, a_idx, a_done};
    assign obs_b = {b_m, b_ten, b_busy, b_idx, b_done};
    assign obs_c = {c_m, c_ten, c_busy, c_idx, c_done};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLOCK = ~CLOCK;

    tone_sequencer #(.TICK_DIV(4), .GAP_UNITS(1), .NOTE_COUNT(16), .ADDR_W(4), .MELODY(MEL_TEST)) u_dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .START(a_start), .STOP(STOP), .LOOP(LOOP),
        .m(a_m), .TONE_EN(a_ten), .BUSY(a_busy), .NOTE_IDX(a_idx), .DONE(a_done));

    tone_sequencer #(.TICK_DIV(4), .GAP_UNITS(1), .NOTE_COUNT(16), .ADDR_W(4), .MELODY(MEL_WRAP)) u_dut_b (
        .CLOCK(CLOCK), .RESET(RESET), .START(b_start), .STOP(STOP), .LOOP(LOOP),
        .m(b_m), .TONE_EN(b_ten), .BUSY(b_busy), .NOTE_IDX(b_idx), .DONE(b_done));

    tone_sequencer #(.TICK_DIV(4), .GAP_UNITS(1), .NOTE_COUNT(16), .ADDR_W(4), .MELODY(MEL_EMPTY)) u_dut_c (
        .CLOCK(CLOCK), .RESET(RESET), .START(c_start), .STOP(STOP), .LOOP(LOOP),
        .m(c_m), .TONE_EN(c_ten), .BUSY(c_busy), .NOTE_IDX(c_idx), .DONE(c_done));

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    // Expected {m, TONE_EN, BUSY, NOTE_IDX, DONE} for cycle c after START, test melody, LOOP=0
    function automatic logic [38:0] model_a(input int c);
        if (c <= 8)       return {32'd1000, 1'b1, 1'b1, 4'd0, 1'b0};
        else if (c <= 12) return {32'd0,    1'b0, 1'b1, 4'd0, 1'b0};
        else if (c <= 20) return {32'd0,    1'b0, 1'b1, 4'd1, 1'b0};
        else if (c <= 24) return {32'd2000, 1'b1, 1'b1, 4'd2, 1'b0};
        else if (c <= 28) return {32'd0,    1'b0, 1'b1, 4'd2, 1'b0};
        else if (c == 29) return {32'd0,    1'b0, 1'b0, 4'd0, 1'b1};
        else              return 39'd0;
    endfunction

    // Wrap melody: 16 entries of one unit (4 cycles) plus a 4-cycle gap each
    function automatic logic [38:0] model_b(input int c);
        int e;
        int ph;
        logic [3:0] ei;
        if (c == 129) return {32'd0, 1'b0, 1'b0, 4'd0, 1'b1};
        if (c > 129)  return 39'd0;
        e  = (c - 1) / 8;
        ph = (c - 1) % 8;
        ei = 4'(e);
        if (ph < 4) return {32'(100 * (e + 1)), 1'b1, 1'b1, ei, 1'b0};
        else        return {32'd0,              1'b0, 1'b1, ei, 1'b0};
    endfunction

    task automatic test_reset();
        RESET = 1'b1;
        step(); step(); step();
        n_checks++;
        if (obs_a !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_a: got %h, expected %h", obs_a, 39'd0);
        end
        n_checks++;
        if (obs_b !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %h, expected %h", obs_b, 39'd0);
        end
        n_checks++;
        if (obs_c !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_c: got %h, expected %h", obs_c, 39'd0);
        end
        RESET = 1'b0;
        step();
    endtask

    task automatic test_timing();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            n_checks++;
            if (obs_a !== model_a(c)) begin
                n_fail++;
                $display("FAIL timing cycle %0d: got %h, expected %h", c, obs_a, model_a(c));
            end
            step();
        end
    endtask

    task automatic test_loop();
        logic [38:0] exp_v;
        LOOP = 1'b1;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            exp_v = (c <= 28) ? model_a(c) : model_a(c - 28);
            n_checks++;
            if (obs_a !== exp_v) begin
                n_fail++;
                $display("FAIL loop cycle %0d: got %h, expected %h", c, obs_a, exp_v);
            end
            step();
        end
        STOP = 1'b1;
        LOOP = 1'b0;
        step();
        STOP = 1'b0;
        n_checks++;
        if (obs_a !== 39'd0) begin
            n_fail++;
            $display("FAIL loop_stop: got %h, expected %h", obs_a, 39'd0);
        end
        step();
    endtask

    task automatic test_stop();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_checks++;
            if (obs_a !== model_a(c)) begin
                n_fail++;
                $display("FAIL stop_pre cycle %0d: got %h, expected %h", c, obs_a, model_a(c));
            end
            if (c < 3) step();
        end
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_a !== 39'd0) begin
                n_fail++;
                $display("FAIL stop_idle %0d: got %h, expected %h", k, obs_a, 39'd0);
            end
            step();
        end
        a_start = 1'b1;
        STOP = 1'b1;
        step();
        a_start = 1'b0;
        STOP = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_a !== 39'd0) begin
                n_fail++;
                $display("FAIL start_stop_same %0d: got %h, expected %h", k, obs_a, 39'd0);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        a_start = 1'b1;
        step();
        for (int c = 1; c <= 30; c++) begin
            a_start = (c == 2 || c == 9 || c == 14 || c == 21 || c == 28 || c == 29);
            n_checks++;
            if (obs_a !== model_a(c)) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h, expected %h", c, obs_a, model_a(c));
            end
            step();
        end
        a_start = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_gap();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            n_checks++;
            if (obs_a !== model_a(c)) begin
                n_fail++;
                $display("FAIL pre_reset cycle %0d: got %h, expected %h", c, obs_a, model_a(c));
            end
            if (c < 10) step();
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_a !== 39'd0) begin
                n_fail++;
                $display("FAIL reset_mid_gap %0d: got %h, expected %h", k, obs_a, 39'd0);
            end
            step();
        end
    endtask

    task automatic test_wrap();
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int c = 1; c <= 130; c++) begin
            n_checks++;
            if (obs_b !== model_b(c)) begin
                n_fail++;
                $display("FAIL wrap cycle %0d: got %h, expected %h", c, obs_b, model_b(c));
            end
            step();
        end
    endtask

    task automatic test_empty();
        c_start = 1'b1;
        step();
        c_start = 1'b0;
        n_checks++;
        if (obs_c !== {32'd0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL empty_done: got %h, expected %h", obs_c, {32'd0, 1'b0, 1'b0, 4'd0, 1'b1});
        end
        step();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_c !== 39'd0) begin
                n_fail++;
                $display("FAIL empty_idle %0d: got %h, expected %h", k, obs_c, 39'd0);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_loop();
        test_stop();
        test_back_to_back();
        test_reset_mid_gap();
        test_wrap();
        test_empty();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
